ln_app_scheduler: RTL

Round-robin scheduler that shares one `final_application_unit` (LayerNorm apply stage, y = γ·(x−μ)·inv_std + β) between `N_REQ` LayerNorm statistics producers, e.g. pre-attention LN and pre-FFN LN.

- Per job: arbitrates requests, latches that requester's μ / inv_std scalars and tag, and issues a single-cycle start pulse.
- Drives a select index that steers the external x/γ/β vector muxes.
- Waits for the unit's valid pulse, with a timeout, then returns a response under valid/ready handshake.

The y vector does not pass through this block. The consumer captures `y_vector_out` while `rsp_valid_out` is high.

---
 rtl/ln_app_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ln_app_scheduler.sv
// Round-robin scheduler sharing one LayerNorm apply unit between N_REQ statistics producers.
// Latches the winner's mu/inv_std/tag, pulses start, waits for valid (or timeout), then responds.
//
// state | meaning
// IDLE  | waiting for a request while the unit is not busy
// ISSUE | start pulse is high, timeout counter cleared
// RUN   | unit computing, counting towards timeout
// RESP  | response held until the consumer accepts it
module ln_app_scheduler #(
    parameter int N_REQ          = 2,
    parameter int MU_WIDTH       = 24,
    parameter int INV_STD_WIDTH  = 24,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid_in,
    output logic [N_REQ-1:0]                 req_ready_out,
    input  logic [N_REQ*MU_WIDTH-1:0]        req_mu_in,
    input  logic [N_REQ*INV_STD_WIDTH-1:0]   req_inv_std_in,
    input  logic [N_REQ*TAG_WIDTH-1:0]       req_tag_in,
    output logic                             app_start_out,
    output logic [MU_WIDTH-1:0]              app_mu_out,
    output logic [INV_STD_WIDTH-1:0]         app_inv_std_out,
    output logic [$clog2(N_REQ)-1:0]         app_sel_out,
    input  logic                             app_busy_in,
    input  logic                             app_valid_in,
    output logic                             rsp_valid_out,
    input  logic                             rsp_ready_in,
    output logic [$clog2(N_REQ)-1:0]         rsp_id_out,
    output logic [TAG_WIDTH-1:0]             rsp_tag_out,
    output logic                             rsp_err_out,
    output logic                             err_sticky_out
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [SEL_W-1:0] LAST_RESET  = SEL_W'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_RESP} state_t;

    state_t state, state_nxt;

    logic [SEL_W-1:0]         last_grant;
    logic [SEL_W-1:0]         grant_idx;
    logic [SEL_W-1:0]         cand_idx;
    logic                     grant_found;
    logic                     accept;
    logic                     run_valid;
    logic                     run_timeout;
    logic                     rsp_accept;
    logic [CNT_W-1:0]         cnt;
    logic [MU_WIDTH-1:0]      mu_sel;
    logic [INV_STD_WIDTH-1:0] inv_sel;
    logic [TAG_WIDTH-1:0]     tag_sel;

    // Rotating-priority search starting just after the previous winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = SEL_W'((int'(last_grant) + k) % N_REQ);
            if (!grant_found && req_valid_in[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        mu_sel  = '0;
        inv_sel = '0;
        tag_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                mu_sel  = req_mu_in[i*MU_WIDTH +: MU_WIDTH];
                inv_sel = req_inv_std_in[i*INV_STD_WIDTH +: INV_STD_WIDTH];
                tag_sel = req_tag_in[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready_out = '0;
        accept        = 1'b0;
        run_valid     = 1'b0;
        run_timeout   = 1'b0;
        rsp_accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found && !app_busy_in) begin
                    req_ready_out[grant_idx] = 1'b1;
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_RUN;
            S_RUN: begin
                // A valid arriving on the timeout cycle still counts as success
                if (app_valid_in) begin
                    run_valid = 1'b1;
                    state_nxt = S_RESP;
                end else if (cnt == TIMEOUT_VAL) begin
                    run_timeout = 1'b1;
                    state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_in) begin
                    rsp_accept = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant      <= LAST_RESET;
            app_start_out   <= 1'b0;
            app_mu_out      <= '0;
            app_inv_std_out <= '0;
            app_sel_out     <= '0;
            rsp_tag_out     <= '0;
            rsp_valid_out   <= 1'b0;
            rsp_err_out     <= 1'b0;
            err_sticky_out  <= 1'b0;
            cnt             <= '0;
        end else begin
            app_start_out <= accept;
            if (accept) begin
                app_mu_out      <= mu_sel;
                app_inv_std_out <= inv_sel;
                app_sel_out     <= grant_idx;
                rsp_tag_out     <= tag_sel;
                last_grant      <= grant_idx;
            end
            if (state == S_ISSUE) cnt <= '0;
            else if (state == S_RUN) cnt <= cnt + 1'b1;
            if (run_valid || run_timeout) begin
                rsp_valid_out <= 1'b1;
                rsp_err_out   <= run_timeout;
            end else if (rsp_accept) begin
                rsp_valid_out <= 1'b0;
                rsp_err_out   <= 1'b0;
            end
            if (run_timeout) err_sticky_out <= 1'b1;
        end
    end

    assign rsp_id_out = app_sel_out;

endmodule
